mem_ldst_unit: RTL and testbench
================================

// Module: mem_ldst_unit
// PURPOSE
//   Sub-word load/store unit for the MEM stage of the pipelined CPU.
//   Stores: narrows 32-bit store data into byte lanes with byte enables.
//   Loads: sign- or zero-extends the returned byte/half to 32 bits.
//   Drives a multi-cycle data-memory bus (req/ack) and raises busy to stall the pipeline.
// PARAMETERS
//   TIMEOUT  255  max cycles waiting for bus_ack before giving up with resp_err (>=1)
// PORTS
//   clk        in   1   clock; single clock domain
//   reset      in   1   synchronous, active-high reset
//   req_valid  in   1   MEM-stage request present
//   req_ready  out  1   unit can accept a request (=1 only in IDLE)
//   req_we     in   1   1=store, 0=load
//   req_type   in   3   0 word, 1 half signed, 2 half unsigned, 3 byte signed, 4 byte unsigned; 5-7 illegal
//   req_addr   in   32  byte address
//   req_wdata  in   32  store data (sub-word in low bits)
//   bus_req    out  1   bus transaction request, held until ack
//   bus_we     out  1   bus write enable
//   bus_addr   out  32  word address {req_addr[31:2],2'b00}
//   bus_be     out  4   byte enables, lane i = bits [8i+7:8i]
//   bus_wdata  out  32  lane-replicated store data
//   bus_ack    in   1   bus completes transaction this cycle
//   bus_rdata  in   32  read word, valid when bus_ack=1
//   resp_valid out  1   one-cycle pulse: access finished
//   resp_rdata out  32  extended load data (0 for stores/errors)
//   resp_err   out  1   misaligned, illegal type or timeout; valid with resp_valid
//   busy       out  1   =~req_ready; pipeline stall
// BEHAVIOUR
//   - Reset: state IDLE; req_ready=1, busy=0; bus_req, bus_we, resp_valid, resp_err =0;
//     bus_addr, bus_be, bus_wdata, resp_rdata =0; timeout counter =0.
//   - FSM: IDLE -> BUS (req_valid & legal & aligned) | ERR (req_valid & fault).
//     BUS -> RESP on bus_ack; BUS -> ERR when counter reaches TIMEOUT without ack.
//     RESP -> IDLE and ERR -> IDLE unconditionally. Request fields latched on accept.
//   - Alignment: word needs addr[1:0]=0; half needs addr[0]=0; byte always aligned.
//     Fault => no bus activity, resp_err=1, resp_rdata=0.
//   - Latency: accept at edge N; bus_req=1 from cycle N+1; ack seen at edge M;
//     resp_valid=1 in cycle M+1 only. Minimum accept-to-resp = 2 cycles; fault = 1 cycle.
//   - bus_req, bus_we, bus_addr, bus_be, bus_wdata are registered and stable while bus_req=1;
//     bus_req drops the cycle after ack.
//   - Store lanes (little-endian): byte be=4'b0001<<addr[1:0], wdata={4{wd[7:0]}};
//     half be=addr[1]?4'b1100:4'b0011, wdata={2{wd[15:0]}}; word be=4'hF, wdata=wd.
//   - Load extract: byte=rdata[8*addr[1:0]+:8]; half=rdata[16*addr[1]+:16];
//     signed types replicate the MSB, unsigned types zero-fill. Loads drive bus_be=4'hF.
//   - Stores: resp_rdata=0. resp_valid has no backpressure; consumer must sample.
//   - Timeout: counter clears on entering BUS, increments each BUS cycle without ack;
//     at TIMEOUT drop bus_req, resp_err=1. An ack arriving after the timeout is ignored.
//   - req_valid while busy is not accepted; the requester holds the request.
//   - Reset mid-transaction: return to IDLE, drop bus_req, no resp_valid; later acks ignored.
//   - bus_ack in IDLE/RESP/ERR: ignored.
// TESTING
//   - lb addr=0x1003, rdata=0x80FF_1234 -> be=4'hF, resp_rdata=0xFFFF_FF80, err=0.
//   - lhu addr=0x2002, rdata=0xBEEF_0000 -> resp_rdata=0x0000_BEEF; lh same -> 0xFFFF_BEEF.
//   - sb addr=0x11, wd=0xAB -> bus_addr=0x10, be=4'b0010, wdata=0xABAB_ABAB; sh addr=0x12 -> be=4'b1100.
//   - lw addr=0x6 -> no bus_req, resp_valid 1 cycle after accept, err=1; req_type=7 -> same.
//   - TIMEOUT=4, no ack -> bus_req high 4 cycles then low, err=1; late ack ignored.
//   - reset asserted while bus_req=1 -> next cycle bus_req=0, req_ready=1, no resp_valid.

Source files
------------

// File: rtl/mem_ldst_unit.sv
// Sub-word load/store unit for the MEM stage: lane/byte-enable generation for stores,
// sign/zero extension for loads, and a req/ack data bus handshake with a timeout.
module mem_ldst_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [2:0] T_WORD = 3'd0, T_HS = 3'd1, T_HU = 3'd2, T_BS = 3'd3, T_BU = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP, S_ERR} state_t;

  state_t      state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]  type_reg, type_next;
  logic [1:0]  off_reg, off_next;
  logic        we_reg, we_next;
  logic        bus_req_reg, bus_req_next;
  logic        bus_we_reg, bus_we_next;
  logic [31:0] bus_addr_reg, bus_addr_next;
  logic [3:0]  bus_be_reg, bus_be_next;
  logic [31:0] bus_wdata_reg, bus_wdata_next;
  logic        resp_valid_reg, resp_valid_next;
  logic        resp_err_reg, resp_err_next;
  logic [31:0] resp_rdata_reg, resp_rdata_next;

  logic        legal, aligned;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [7:0]  rd_lane [4];
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] ld_data;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign rd_lane[gi] = bus_rdata[8*gi +: 8];
    end
  endgenerate

  assign rd_byte = rd_lane[off_reg];
  assign rd_half = off_reg[1] ? {rd_lane[3], rd_lane[2]} : {rd_lane[1], rd_lane[0]};

  always_comb begin
    legal    = (req_type <= T_BU);
    aligned  = 1'b1;
    st_be    = 4'hF;
    st_wdata = 32'h0;
    case (req_type)
      T_WORD: begin
        aligned  = (req_addr[1:0] == 2'b00);
        st_wdata = req_wdata;
      end
      T_HS, T_HU: begin
        aligned  = ~req_addr[0];
        st_be    = req_addr[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{req_wdata[15:0]}};
      end
      T_BS, T_BU: begin
        st_be    = 4'b0001 << req_addr[1:0];
        st_wdata = {4{req_wdata[7:0]}};
      end
      default: ;
    endcase
    // Loads always fetch the whole word; extraction happens on the way back.
    if (!req_we) begin
      st_be    = 4'hF;
      st_wdata = 32'h0;
    end
  end

  always_comb begin
    ld_data = 32'h0;
    case (type_reg)
      T_WORD:  ld_data = bus_rdata;
      T_HS:    ld_data = {{16{rd_half[15]}}, rd_half};
      T_HU:    ld_data = {16'h0, rd_half};
      T_BS:    ld_data = {{24{rd_byte[7]}}, rd_byte};
      T_BU:    ld_data = {24'h0, rd_byte};
      default: ld_data = 32'h0;
    endcase
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    type_next       = type_reg;
    off_next        = off_reg;
    we_next         = we_reg;
    bus_req_next    = bus_req_reg;
    bus_we_next     = bus_we_reg;
    bus_addr_next   = bus_addr_reg;
    bus_be_next     = bus_be_reg;
    bus_wdata_next  = bus_wdata_reg;
    resp_valid_next = 1'b0;
    resp_err_next   = 1'b0;
    resp_rdata_next = 32'h0;
    case (state_reg)
      S_IDLE: begin
        if (req_valid) begin
          if (legal && aligned) begin
            state_next     = S_BUS;
            cnt_next       = '0;
            type_next      = req_type;
            off_next       = req_addr[1:0];
            we_next        = req_we;
            bus_req_next   = 1'b1;
            bus_we_next    = req_we;
            bus_addr_next  = {req_addr[31:2], 2'b00};
            bus_be_next    = st_be;
            bus_wdata_next = st_wdata;
          end else begin
            state_next      = S_ERR;
            resp_valid_next = 1'b1;
            resp_err_next   = 1'b1;
          end
        end
      end
      S_BUS: begin
        if (bus_ack) begin
          state_next      = S_RESP;
          bus_req_next    = 1'b0;
          bus_we_next     = 1'b0;
          resp_valid_next = 1'b1;
          resp_rdata_next = we_reg ? 32'h0 : ld_data;
        end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
          // Last allowed bus cycle passed without ack: abandon the access.
          state_next      = S_ERR;
          bus_req_next    = 1'b0;
          bus_we_next     = 1'b0;
          resp_valid_next = 1'b1;
          resp_err_next   = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_RESP, S_ERR: state_next = S_IDLE;
      default:       state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      cnt_reg        <= '0;
      type_reg       <= 3'd0;
      off_reg        <= 2'd0;
      we_reg         <= 1'b0;
      bus_req_reg    <= 1'b0;
      bus_we_reg     <= 1'b0;
      bus_addr_reg   <= 32'h0;
      bus_be_reg     <= 4'h0;
      bus_wdata_reg  <= 32'h0;
      resp_valid_reg <= 1'b0;
      resp_err_reg   <= 1'b0;
      resp_rdata_reg <= 32'h0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      type_reg       <= type_next;
      off_reg        <= off_next;
      we_reg         <= we_next;
      bus_req_reg    <= bus_req_next;
      bus_we_reg     <= bus_we_next;
      bus_addr_reg   <= bus_addr_next;
      bus_be_reg     <= bus_be_next;
      bus_wdata_reg  <= bus_wdata_next;
      resp_valid_reg <= resp_valid_next;
      resp_err_reg   <= resp_err_next;
      resp_rdata_reg <= resp_rdata_next;
    end
  end

  assign req_ready  = (state_reg == S_IDLE);
  assign busy       = ~req_ready;
  assign bus_req    = bus_req_reg;
  assign bus_we     = bus_we_reg;
  assign bus_addr   = bus_addr_reg;
  assign bus_be     = bus_be_reg;
  assign bus_wdata  = bus_wdata_reg;
  assign resp_valid = resp_valid_reg;
  assign resp_err   = resp_err_reg;
  assign resp_rdata = resp_rdata_reg;

endmodule

// File: tb/tb_mem_ldst_unit.sv
// Directed bench for mem_ldst_unit: expected bus transfers and responses are queued when a
// request is driven and compared when the unit produces them.
module tb_mem_ldst_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_type;
  logic [31:0] req_addr, req_wdata;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic        resp_valid, resp_err, busy;
  logic [31:0] resp_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_exp_t;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } resp_exp_t;

  bus_exp_t  bus_q[$];
  resp_exp_t resp_q[$];

  always #5 clk = ~clk;

  mem_ldst_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_type(req_type),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One access: ack_at is the bus_req cycle (1-based) in which ack is driven, 0 = never.
  task automatic run(input string name, input logic we, input logic [2:0] typ,
                     input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                     input int ack_at, input int exp_bcyc, input int exp_lat,
                     input logic [31:0] e_baddr, input logic [3:0] e_be, input logic [31:0] e_bwd,
                     input logic e_err, input logic [31:0] e_rd);
    bus_exp_t  cur;
    resp_exp_t r;
    int bcnt = 0;
    bit got = 0;
    if (exp_bcyc > 0) bus_q.push_back('{we: we, addr: e_baddr, be: e_be, wdata: e_bwd});
    resp_q.push_back('{err: e_err, rdata: e_rd});
    cur = '0;
    check({name, " ready"}, {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_we = we; req_type = typ; req_addr = addr; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 1; i <= 30 && !got; i++) begin
      bus_ack = 1'b0;
      if (bus_req) begin
        bcnt++;
        if (bcnt == 1) begin
          if (bus_q.size() == 0) check({name, " unexpected_bus_req"}, 32'h1, 32'h0);
          else cur = bus_q.pop_front();
        end
        check({name, " bus_we"}, {31'h0, bus_we}, {31'h0, cur.we});
        check({name, " bus_addr"}, bus_addr, cur.addr);
        check({name, " bus_be"}, {28'h0, bus_be}, {28'h0, cur.be});
        if (cur.we) check({name, " bus_wdata"}, bus_wdata, cur.wdata);
        check({name, " busy"}, {31'h0, busy}, 32'h1);
        if (bcnt == ack_at) begin
          bus_ack = 1'b1;
          bus_rdata = rd;
        end
      end
      if (resp_valid) begin
        got = 1;
        r = resp_q.pop_front();
        check({name, " resp_err"}, {31'h0, resp_err}, {31'h0, r.err});
        check({name, " resp_rdata"}, resp_rdata, r.rdata);
        check({name, " latency"}, i, exp_lat);
      end
      @(negedge clk);
    end
    bus_ack = 1'b0;
    bus_rdata = 32'h0;
    if (!got) check({name, " resp_seen"}, 32'h0, 32'h1);
    check({name, " bus_cycles"}, bcnt, exp_bcyc);
    check({name, " resp_pulse"}, {31'h0, resp_valid}, 32'h0);
    check({name, " bus_req_low"}, {31'h0, bus_req}, 32'h0);
    check({name, " idle_busy"}, {31'h0, busy}, 32'h0);
    $display("txn %s we=%0d type=%0d addr=%h bus_cycles=%0d done", name, we, typ, addr, bcnt);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_type = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
    repeat (3) @(negedge clk);
    check("rst req_ready", {31'h0, req_ready}, 32'h1);
    check("rst busy", {31'h0, busy}, 32'h0);
    check("rst bus_req", {31'h0, bus_req}, 32'h0);
    check("rst bus_we", {31'h0, bus_we}, 32'h0);
    check("rst bus_addr", bus_addr, 32'h0);
    check("rst bus_be", {28'h0, bus_be}, 32'h0);
    check("rst bus_wdata", bus_wdata, 32'h0);
    check("rst resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst resp_err", {31'h0, resp_err}, 32'h0);
    check("rst resp_rdata", resp_rdata, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    //   name     we  typ   addr          wd            rd            ack bcyc lat baddr         be     bwd           err  rdata
    run("lb",    0, 3'd3, 32'h0000_1003, 32'h0,        32'h80FF_1234, 1, 1, 2, 32'h0000_1000, 4'hF,  32'h0,        0, 32'hFFFF_FF80);
    run("lhu",   0, 3'd2, 32'h0000_2002, 32'h0,        32'hBEEF_0000, 3, 3, 4, 32'h0000_2000, 4'hF,  32'h0,        0, 32'h0000_BEEF);
    run("lh",    0, 3'd1, 32'h0000_2002, 32'h0,        32'hBEEF_0000, 2, 2, 3, 32'h0000_2000, 4'hF,  32'h0,        0, 32'hFFFF_BEEF);
    run("lh_pos",0, 3'd1, 32'h0000_3000, 32'h0,        32'h1111_7FFF, 1, 1, 2, 32'h0000_3000, 4'hF,  32'h0,        0, 32'h0000_7FFF);
    run("lbu",   0, 3'd4, 32'h0000_1001, 32'h0,        32'h0000_80AB, 1, 1, 2, 32'h0000_1000, 4'hF,  32'h0,        0, 32'h0000_0080);
    run("lw",    0, 3'd0, 32'h0000_0040, 32'h0,        32'h1234_5678, 4, 4, 5, 32'h0000_0040, 4'hF,  32'h0,        0, 32'h1234_5678);
    run("sb",    1, 3'd3, 32'h0000_0011, 32'h0000_00AB, 32'hFFFF_FFFF, 1, 1, 2, 32'h0000_0010, 4'b0010, 32'hABAB_ABAB, 0, 32'h0);
    run("sh",    1, 3'd1, 32'h0000_0012, 32'h5555_1234, 32'hFFFF_FFFF, 2, 2, 3, 32'h0000_0010, 4'b1100, 32'h1234_1234, 0, 32'h0);
    run("sw",    1, 3'd0, 32'h0000_0020, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1, 1, 2, 32'h0000_0020, 4'hF,  32'hDEAD_BEEF, 0, 32'h0);
    run("lw_mis",0, 3'd0, 32'h0000_0006, 32'h0,        32'h0,         1, 0, 1, 32'h0,        4'h0,  32'h0,        1, 32'h0);
    run("sh_mis",1, 3'd2, 32'h0000_0013, 32'h0000_1234, 32'h0,        1, 0, 1, 32'h0,        4'h0,  32'h0,        1, 32'h0);
    run("ill7",  0, 3'd7, 32'h0000_0000, 32'h0,        32'h0,         1, 0, 1, 32'h0,        4'h0,  32'h0,        1, 32'h0);
    run("tmo",   0, 3'd0, 32'h0000_0100, 32'h0,        32'hCAFE_F00D, 0, TO, TO + 1, 32'h0000_0100, 4'hF, 32'h0, 1, 32'h0);

    // Late acks after the timeout must not produce a response.
    bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("late_ack resp_valid", {31'h0, resp_valid}, 32'h0);
      check("late_ack bus_req", {31'h0, bus_req}, 32'h0);
    end
    bus_ack = 1'b0;
    $display("txn late_ack ignored");

    // Reset in the middle of a bus transaction.
    req_valid = 1'b1; req_we = 1'b0; req_type = 3'd0; req_addr = 32'h0000_0200;
    @(negedge clk);
    req_valid = 1'b0;
    check("midrst bus_req_up", {31'h0, bus_req}, 32'h1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst bus_req", {31'h0, bus_req}, 32'h0);
    check("midrst req_ready", {31'h0, req_ready}, 32'h1);
    check("midrst resp_valid", {31'h0, resp_valid}, 32'h0);
    reset = 1'b0;
    bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("midrst late_ack resp_valid", {31'h0, resp_valid}, 32'h0);
      check("midrst late_ack req_ready", {31'h0, req_ready}, 32'h1);
    end
    bus_ack = 1'b0;
    $display("txn mid_reset recovered");

    run("post",  0, 3'd4, 32'h0000_0403, 32'h0,        32'h7F00_0000, 1, 1, 2, 32'h0000_0400, 4'hF,  32'h0,        0, 32'h0000_007F);

    check("queues_drained", bus_q.size() + resp_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
